switch_debounce: RTL and testbench



---
 rtl/switch_debounce.sv | 95 +++++++++
 tb/tb_switch_debounce.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// Per-channel push-button conditioner: two-flop synchronizer, consecutive-sample
// debouncer, registered press/release strobes and a one-shot long-press strobe.
module switch_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 66000,
    parameter int HOLD_CYCLES     = 66000000
) (
    input  logic             CLK_66MHZ,
    input  logic             USER_RESET,
    input  logic [WIDTH-1:0] SW_IN,
    output logic [WIDTH-1:0] SW_LEVEL,
    output logic [WIDTH-1:0] SW_PRESS,
    output logic [WIDTH-1:0] SW_RELEASE,
    output logic [WIDTH-1:0] SW_HOLD
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HCNT_PRE  = HW'(HOLD_CYCLES - 1);

    // Bit 1 of the state is the debounced level itself.
    localparam logic [1:0] STABLE_LO = 2'b00;
    localparam logic [1:0] PEND_HI   = 2'b01;
    localparam logic [1:0] STABLE_HI = 2'b10;
    localparam logic [1:0] PEND_LO   = 2'b11;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic          s1;
        logic          s2;
        logic [1:0]    state;
        logic [DW-1:0] dcnt;
        logic [HW-1:0] hcnt;
        logic          press;
        logic          rel;
        logic          hold;
        logic          level;

        assign level = state[1];

        always_ff @(posedge CLK_66MHZ or posedge USER_RESET) begin
            if (USER_RESET) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                state <= STABLE_LO;
                dcnt  <= '0;
                press <= 1'b0;
                rel   <= 1'b0;
            end else begin
                s1    <= SW_IN[i];
                s2    <= s1;
                press <= 1'b0;
                rel   <= 1'b0;
                if (s2 == level) begin
                    // Any matching sample abandons a pending change.
                    dcnt  <= '0;
                    state <= level ? STABLE_HI : STABLE_LO;
                end else if (dcnt != DCNT_LAST) begin
                    dcnt  <= dcnt + 1'b1;
                    state <= level ? PEND_LO : PEND_HI;
                end else begin
                    dcnt  <= '0;
                    state <= s2 ? STABLE_HI : STABLE_LO;
                    press <= s2;
                    rel   <= ~s2;
                end
            end
        end

        // The press edge still sees the old low level, so hcnt starts from zero
        // and the hold strobe can never share a cycle with the press strobe.
        always_ff @(posedge CLK_66MHZ or posedge USER_RESET) begin
            if (USER_RESET) begin
                hcnt <= '0;
                hold <= 1'b0;
            end else if (!level) begin
                hcnt <= '0;
                hold <= 1'b0;
            end else begin
                if (hcnt != HCNT_MAX) begin
                    hcnt <= hcnt + 1'b1;
                end
                hold <= (hcnt == HCNT_PRE);
            end
        end

        assign SW_LEVEL[i]   = level;
        assign SW_PRESS[i]   = press;
        assign SW_RELEASE[i] = rel;
        assign SW_HOLD[i]    = hold;
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: directed scenarios plus random per-channel bouncing,
// every cycle compared against a sample-window reference model.
module tb_switch_debounce;

    localparam int W = 4;
    localparam int D = 4;
    localparam int H = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw_in;
    logic [W-1:0] lvl_o;
    logic [W-1:0] press_o;
    logic [W-1:0] rel_o;
    logic [W-1:0] hold_o;

    always #5 clk = ~clk;

    switch_debounce #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES(H)
    ) dut (
        .CLK_66MHZ(clk),
        .USER_RESET(rst),
        .SW_IN(sw_in),
        .SW_LEVEL(lvl_o),
        .SW_PRESS(press_o),
        .SW_RELEASE(rel_o),
        .SW_HOLD(hold_o)
    );

    int checks = 0;
    int errors = 0;

    // Model: hist[c][k] is the raw input sampled k edges ago. A level change is
    // accepted when the D samples that have cleared the synchronizer all differ.
    logic [D+1:0] hist [W];
    logic         m_lvl [W];
    int           m_run [W];
    logic [W-1:0] e_lvl, e_press, e_rel, e_hold;

    int edge_no;
    int pcnt [W];
    int rcnt [W];
    int hcnt [W];
    int pedge [W];
    int redge [W];
    int hedge [W];
    int coinc;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_rec();
        edge_no = 0;
        coinc   = 0;
        for (int c = 0; c < W; c++) begin
            pcnt[c] = 0; rcnt[c] = 0; hcnt[c] = 0;
            pedge[c] = -1; redge[c] = -1; hedge[c] = -1;
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < W; c++) begin
            hist[c]  = '0;
            m_lvl[c] = 1'b0;
            m_run[c] = 0;
        end
        e_lvl = '0; e_press = '0; e_rel = '0; e_hold = '0;
    endtask

    task automatic model_edge(input logic [W-1:0] v);
        logic prev;
        logic flip;
        for (int c = 0; c < W; c++) begin
            hist[c] = {hist[c][D:0], v[c]};
            prev = m_lvl[c];
            flip = 1'b1;
            for (int k = 2; k <= D + 1; k++) begin
                if (hist[c][k] == prev) flip = 1'b0;
            end
            // Hold fires when the level has been high for exactly H edges.
            e_hold[c]  = (m_run[c] == H);
            e_press[c] = flip & ~prev;
            e_rel[c]   = flip & prev;
            if (flip) m_lvl[c] = ~prev;
            e_lvl[c] = m_lvl[c];
            m_run[c] = m_lvl[c] ? m_run[c] + 1 : 0;
        end
    endtask

    task automatic step(input logic [W-1:0] v);
        sw_in = v;
        @(posedge clk);
        model_edge(v);
        #1;
        chk("level", lvl_o, e_lvl);
        chk("press", press_o, e_press);
        chk("release", rel_o, e_rel);
        chk("hold", hold_o, e_hold);
        for (int c = 0; c < W; c++) begin
            if (press_o[c]) begin pcnt[c]++; pedge[c] = edge_no; end
            if (rel_o[c])   begin rcnt[c]++; redge[c] = edge_no; end
            if (hold_o[c])  begin hcnt[c]++; hedge[c] = edge_no; end
        end
        if (press_o[0] && rel_o[3]) coinc = 1;
        edge_no++;
    endtask

    task automatic repeat_step(input logic [W-1:0] v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    // Asserts reset between edges and expects every output low immediately.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_level", lvl_o, '0);
        chk("rst_press", press_o, '0);
        chk("rst_release", rel_o, '0);
        chk("rst_hold", hold_o, '0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clr_rec();
    endtask

    initial begin
        int dur [W];
        logic [W-1:0] rv;

        sw_in = '0;
        rst   = 1'b0;
        #2;
        do_reset();

        // Clean press on channel 0
        repeat_step(4'b0001, 10);
        chk_int("clean_press_edge", pedge[0], 5);
        chk_int("clean_press_count", pcnt[0], 1);
        chk_int("clean_other_press", pcnt[1] + pcnt[2] + pcnt[3], 0);

        // Bounce then glitch on channel 1
        do_reset();
        repeat_step(4'b0010, 3);
        repeat_step(4'b0000, 3);
        repeat_step(4'b0010, 3);
        repeat_step(4'b0000, 3);
        repeat_step(4'b0010, 12);
        repeat_step(4'b0000, 3);
        repeat_step(4'b0010, 10);
        chk_int("bounce_press_count", pcnt[1], 1);
        chk_int("bounce_press_edge", pedge[1], 17);
        chk_int("glitch_release_count", rcnt[1], 0);

        // Long hold on channel 2
        do_reset();
        repeat_step(4'b0100, 30);
        repeat_step(4'b0000, 10);
        chk_int("long_press_edge", pedge[2], 5);
        chk_int("long_hold_edge", hedge[2], 15);
        chk_int("long_hold_count", hcnt[2], 1);
        chk_int("long_release_edge", redge[2], 35);

        // Short hold: level high for 8 cycles only
        do_reset();
        repeat_step(4'b0100, 8);
        repeat_step(4'b0000, 10);
        chk_int("short_press_edge", pedge[2], 5);
        chk_int("short_release_edge", redge[2], 13);
        chk_int("short_hold_count", hcnt[2], 0);

        // Simultaneous activity
        do_reset();
        repeat_step(4'b1111, 10);
        repeat_step(4'b1110, 10);
        repeat_step(4'b0111, 10);
        chk_int("sim_press0_count", pcnt[0], 2);
        chk_int("sim_press0_edge", pedge[0], 25);
        chk_int("sim_release3_edge", redge[3], 25);
        chk_int("sim_coincident", coinc, 1);
        chk_int("sim_press1_count", pcnt[1], 1);

        // Reset mid-debounce on channel 0 while channel 1 is high
        do_reset();
        repeat_step(4'b0010, 8);
        repeat_step(4'b0011, 4);
        #2;
        do_reset();
        repeat_step(4'b0011, 8);
        chk_int("rst_mid_press_edge", pedge[0], 5);
        chk_int("rst_mid_press_count", pcnt[0], 1);

        // Random bouncing, with occasional mid-cycle resets
        do_reset();
        rv = '0;
        for (int c = 0; c < W; c++) dur[c] = 0;
        for (int i = 0; i < 500; i++) begin
            for (int c = 0; c < W; c++) begin
                if (dur[c] == 0) begin
                    rv[c]  = ~rv[c];
                    dur[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 20)
                                                           : $urandom_range(1, 6);
                end
                dur[c]--;
            end
            step(rv);
            if ($urandom_range(0, 149) == 0) begin
                #2;
                do_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
